// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester: state encoding, default widths
// and the sizing rule for the ACCESS wait counter.
package apb_pkg;

    localparam int DEF_DWIDTH  = 8;
    localparam int DEF_AWIDTH  = 8;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } apb_state_e;

    // Counter must hold the value TIMEOUT itself; never narrower than 1 bit.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_TIMEOUT);

endpackage

// File: rtl/apb_master_if.sv
// Command/response port and APB bus of the requester, bundled in one interface.
// The master modport is the requester's view; slave is the system/peripheral view.
interface apb_master_if #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [AWIDTH-1:0] cmd_addr;
    logic [DWIDTH-1:0] cmd_wdata;

    logic              rsp_valid;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AWIDTH-1:0] PADDR;
    logic [DWIDTH-1:0] PWDATA;
    logic [DWIDTH-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; expired_o is high while the count equals LIMIT.
// LIMIT=0 means no limit, so expired_o never asserts.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int            CW  = cnt_width(LIMIT);
    localparam logic [CW-1:0] SAT = (LIMIT == 0) ? {CW{1'b1}} : CW'(LIMIT);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != SAT)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired_o = (LIMIT != 0) && (cnt_q == SAT);

endmodule

// File: rtl/apb_master.sv
// APB requester: one command at a time through SETUP/ACCESS, PREADY wait
// states bounded by an optional timeout, result on a one-cycle strobe.
module apb_master
    import apb_pkg::*;
#(
    parameter int DWIDTH  = DEF_DWIDTH,
    parameter int AWIDTH  = DEF_AWIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic         PCLK,
    input  logic         PRESETn,
    apb_master_if.master bus
);
    apb_state_e        state_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [AWIDTH-1:0] paddr_q;
    logic [DWIDTH-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic [DWIDTH-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              rsp_timeout_q;

    logic accept;
    logic expired;

    assign accept = (state_q == ST_IDLE) && bus.cmd_valid;

    apb_wait_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk_i     (PCLK),
        .rst_ni    (PRESETn),
        .clr_i     (accept),
        .en_i      ((state_q == ST_ACCESS) && !bus.PREADY),
        .expired_o (expired)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= ST_IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    if (accept) begin
                        pwrite_q <= bus.cmd_write;
                        paddr_q  <= bus.cmd_addr;
                        pwdata_q <= bus.cmd_wdata;
                        psel_q   <= 1'b1;
                        state_q  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // PREADY is checked first so a ready slave beats the timeout.
                    if (bus.PREADY) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= bus.PSLVERR;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= pwrite_q ? '0 : bus.PRDATA;
                        state_q       <= ST_IDLE;
                    end else if (expired) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= '0;
                        state_q       <= ST_IDLE;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = (state_q == ST_IDLE);
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester (bridge) that drives the PSEL/PENABLE/PWRITE/PWDATA side of the bus and consumes PRDATA/PREADY/PSLVERR from peripheral register blocks.
- Accepts one command at a time from a local valid/ready command port.
- Runs the APB SETUP/ACCESS sequence, honours PREADY wait states, and bounds them with a timeout.
- Returns read data and status on a one-cycle response strobe; sits between the system control logic and the peripheral register slaves.

Parameters:
- DWIDTH, 8, data width of PWDATA/PRDATA/cmd_wdata/rsp_rdata.
- AWIDTH, 8, address width of PADDR/cmd_addr.
- TIMEOUT, 16, maximum ACCESS wait cycles with PREADY=0 before abort; 0 disables the timeout.

Ports:
- PCLK  input  1  bus clock, all logic on rising edge.
- PRESETn  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  master can accept a command (high only in IDLE).
- cmd_write  input  1  1=write, 0=read.
- cmd_addr  input  AWIDTH  target address.
- cmd_wdata  input  DWIDTH  write data.
- rsp_valid  output  1  one-cycle completion strobe.
- rsp_rdata  output  DWIDTH  read data, valid with rsp_valid.
- rsp_err  output  1  PSLVERR or timeout on the completed transfer.
- rsp_timeout  output  1  completion caused by timeout.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PADDR  output  AWIDTH  APB address.
- PWDATA  output  DWIDTH  APB write data.
- PRDATA  input  DWIDTH  APB read data.
- PREADY  input  1  slave ready / wait-state extend.
- PSLVERR  input  1  slave error, sampled only with PREADY in ACCESS.

Behaviour:
- Reset (PRESETn=0, asynchronous):
  - State goes to IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout and the wait counter all go to 0.
  - cmd_ready is 1 once reset is released.
  - Reset mid-transfer drops PSEL/PENABLE immediately; no response is issued for the aborted transfer.
- All outputs are registered except cmd_ready, which is decoded from the state (state==IDLE).
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - On cmd_valid&&cmd_ready, capture cmd_write/addr/wdata into PWRITE/PADDR/PWDATA and go to SETUP.
  - With no command, PSEL=0 and PENABLE=0; PADDR/PWRITE/PWDATA hold their last values.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0, then go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA stay stable throughout SETUP and ACCESS.
  - PREADY=1 completes the transfer on that edge:
    - Go to IDLE, PSEL=0, PENABLE=0.
    - rsp_valid=1 for the next cycle.
    - rsp_err=PSLVERR, rsp_timeout=0.
    - rsp_rdata=PRDATA for reads, 0 for writes.
  - PREADY=0 with TIMEOUT>0: the wait counter increments. When the counter equals TIMEOUT, abort instead of waiting:
    - Go to IDLE, PSEL=0, PENABLE=0.
    - rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=0 with TIMEOUT=0: wait indefinitely.
  - The counter clears on entry to SETUP.
  - PREADY=1 on the same edge the counter reaches its limit means a normal completion; PREADY wins.
- Latency:
  - Command accept to rsp_valid with zero wait states: 3 cycles (accept edge, SETUP, ACCESS, strobe).
  - Each wait state adds 1 cycle.
  - Minimum spacing between accepted commands: 3 cycles. Back-to-back transfers always pass through IDLE.
- rsp_valid is a single-cycle pulse with no backpressure. rsp_rdata/rsp_err/rsp_timeout hold until the next completion.
- cmd_valid asserted outside IDLE is ignored; it is not queued.
- PSLVERR and PRDATA are ignored outside ACCESS and when PREADY=0.
- Wait counter width is $clog2(TIMEOUT+1), minimum 1. It saturates and must not wrap.

Decomposition:
- Shared package apb_pkg:
  - State encoding (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10).
  - Default widths.
  - A localparam for the timeout counter width function.
- Optional sub-module apb_wait_timer: clear/enable/limit counter producing an expired flag. Everything else stays in apb_master.

Test Plan:
- Write, zero wait: cmd addr=0x04 wdata=0xA5 write=1 -> SETUP cycle with PSEL=1/PENABLE=0, PADDR=0x04, PWDATA=0xA5, PWRITE=1; ACCESS with PENABLE=1; rsp_valid 3 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read with 2 wait states: slave returns PRDATA=0x3C with PREADY low 2 cycles -> PSEL/PENABLE held 3 ACCESS cycles, PADDR stable; rsp_valid at cycle 5; rsp_rdata=0x3C.
- Slave error: read completes with PREADY=1, PSLVERR=1 -> rsp_err=1, rsp_timeout=0. Back-to-back cmd_valid is held; the next accept occurs only when cmd_ready returns high.
- Timeout: TIMEOUT=4, PREADY held 0 -> abort after 4 wait cycles; PSEL drops; rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0. The following command proceeds normally.
- Reset mid-ACCESS: PRESETn low during a waited transfer -> PSEL/PENABLE=0 asynchronously, no rsp_valid, cmd_ready=1 after release.
- Boundary: PREADY rises on the same edge the counter reaches TIMEOUT -> normal completion, rsp_timeout=0. TIMEOUT=0 with 100 wait cycles -> no abort.
